// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: section targets, header field layout,
// FSM state encoding and the default memory geometry of the single-cycle MIPS core.
package boot_loader_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int RF_DEPTH_DEF = 32;
    localparam int IM_DEPTH_DEF = 64;
    localparam int DM_DEPTH_DEF = 64;

    localparam int HDR_TGT_HI = 31;
    localparam int HDR_TGT_LO = 30;
    localparam int HDR_CNT_HI = 15;
    localparam int HDR_CNT_LO = 0;
    localparam int CNT_W      = HDR_CNT_HI - HDR_CNT_LO + 1;

    typedef enum logic [1:0] {
        TGT_RF  = 2'b00,
        TGT_IM  = 2'b01,
        TGT_DM  = 2'b10,
        TGT_END = 2'b11
    } tgt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Valid/ready word stream from the host bridge into the boot loader.
interface boot_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/boot_loader_hdr_decode.sv
// Combinational section-header decoder: splits a header word into target and
// word count, and flags counts that would overrun the target memory.
module boot_loader_hdr_decode
    import boot_loader_pkg::*;
#(
    parameter int RF_DEPTH = RF_DEPTH_DEF,
    parameter int IM_DEPTH = IM_DEPTH_DEF,
    parameter int DM_DEPTH = DM_DEPTH_DEF
) (
    input  logic [31:0]      hdr,
    output tgt_e             target,
    output logic [CNT_W-1:0] count,
    output logic             legal
);

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^hdr[HDR_TGT_LO-1:HDR_CNT_HI+1];

    // An END header carries no payload, so its count field is never checked.
    always_comb begin
        target = tgt_e'(hdr[HDR_TGT_HI:HDR_TGT_LO]);
        count  = hdr[HDR_CNT_HI:HDR_CNT_LO];
        legal  = 1'b1;
        case (target)
            TGT_RF:  legal = (count <= CNT_W'(RF_DEPTH));
            TGT_IM:  legal = (count <= CNT_W'(IM_DEPTH));
            TGT_DM:  legal = (count <= CNT_W'(DM_DEPTH));
            TGT_END: legal = 1'b1;
        endcase
    end

endmodule

// File: rtl/boot_loader.sv
// Streams section headers and payload words into the register bank, instruction
// and data memories, and keeps the CPU stalled until an END header arrives.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RF_DEPTH = RF_DEPTH_DEF,
    parameter int IM_DEPTH = IM_DEPTH_DEF,
    parameter int DM_DEPTH = DM_DEPTH_DEF,
    parameter int ADDR_W   = $clog2(max3(RF_DEPTH, IM_DEPTH, DM_DEPTH))
) (
    input  logic              clk_CPU,
    input  logic              rst_CPU,
    input  logic              start,
    boot_loader_if.slave      stream,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rf_we,
    output logic              im_we,
    output logic              dm_we,
    output logic              busy,
    output logic              cpu_run,
    output logic              err
);

    state_e            state;
    state_e            state_nxt;
    tgt_e              tgt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;

    tgt_e              hdr_tgt;
    logic [CNT_W-1:0]  hdr_cnt;
    logic              hdr_legal;
    logic              beat;
    logic              last_beat;
    logic              load_hdr;

    boot_loader_hdr_decode #(
        .RF_DEPTH (RF_DEPTH),
        .IM_DEPTH (IM_DEPTH),
        .DM_DEPTH (DM_DEPTH)
    ) u_hdr_decode (
        .hdr    (stream.s_data[31:0]),
        .target (hdr_tgt),
        .count  (hdr_cnt),
        .legal  (hdr_legal)
    );

    assign beat      = stream.s_valid && stream.s_ready;
    assign last_beat = ({{(CNT_W-ADDR_W){1'b0}}, addr_q} == (cnt_q - CNT_W'(1)));
    assign load_hdr  = (state == ST_HDR) && (state_nxt == ST_LOAD);

    always_ff @(posedge clk_CPU) begin
        if (rst_CPU) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Header priority: END first, then empty sections, then the depth check.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_HDR;
            ST_HDR: begin
                if (beat) begin
                    if (hdr_tgt == TGT_END)  state_nxt = ST_DONE;
                    else if (hdr_cnt == '0)  state_nxt = ST_HDR;
                    else if (!hdr_legal)     state_nxt = ST_ERR;
                    else                     state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: if (beat && last_beat) state_nxt = ST_HDR;
            ST_DONE: if (start) state_nxt = ST_HDR;
            ST_ERR:  if (start) state_nxt = ST_HDR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stream.s_ready = (state == ST_HDR) || (state == ST_LOAD);
        busy           = (state == ST_HDR) || (state == ST_LOAD);
        cpu_run        = (state == ST_DONE);
        err            = (state == ST_ERR);
    end

    // The address counter stops at count-1 so it can never wrap past the depth.
    always_ff @(posedge clk_CPU) begin
        if (rst_CPU) begin
            tgt_q   <= TGT_RF;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            rf_we   <= 1'b0;
            im_we   <= 1'b0;
            dm_we   <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            im_we <= 1'b0;
            dm_we <= 1'b0;
            if (load_hdr) begin
                tgt_q  <= hdr_tgt;
                cnt_q  <= hdr_cnt;
                addr_q <= '0;
            end
            if ((state == ST_LOAD) && beat) begin
                wr_addr <= addr_q;
                wr_data <= stream.s_data;
                rf_we   <= (tgt_q == TGT_RF);
                im_we   <= (tgt_q == TGT_IM);
                dm_we   <= (tgt_q == TGT_DM);
                if (!last_beat) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scenario bench for boot_loader: expected writes are queued as payload beats are
// driven and retired by a monitor that watches the three write strobes.
module tb_boot_loader;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam logic [1:0] T_RF  = 2'd0;
    localparam logic [1:0] T_IM  = 2'd1;
    localparam logic [1:0] T_DM  = 2'd2;
    localparam logic [1:0] T_END = 2'd3;

    logic          clk_CPU = 1'b0;
    logic          rst_CPU;
    logic          start;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rf_we, im_we, dm_we, busy, cpu_run, err;

    always #5 clk_CPU = ~clk_CPU;

    boot_loader_if #(.DATA_W(DW)) stream_bus ();

    boot_loader #(
        .DATA_W   (DW),
        .RF_DEPTH (32),
        .IM_DEPTH (64),
        .DM_DEPTH (64),
        .ADDR_W   (AW)
    ) dut (
        .clk_CPU (clk_CPU),
        .rst_CPU (rst_CPU),
        .start   (start),
        .stream  (stream_bus),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rf_we   (rf_we),
        .im_we   (im_we),
        .dm_we   (dm_we),
        .busy    (busy),
        .cpu_run (cpu_run),
        .err     (err)
    );

    typedef struct {
        logic [1:0]    tgt;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    logic [1:0] mon_tgt;
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk_CPU) cyc <= cyc + 1;

    // Every strobe must match the oldest queued write, including the cycle it lands in.
    always @(negedge clk_CPU) begin
        if ((rf_we | im_we | dm_we) === 1'b1) begin
            compared++;
            mon_tgt = rf_we ? T_RF : (im_we ? T_IM : T_DM);
            if ($countones({rf_we, im_we, dm_we}) != 1) begin
                mismatched++;
                $display("[TB] FAIL strobe_onehot: got %b required exactly one set", {rf_we, im_we, dm_we});
            end else if (sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: got tgt %0d addr %0d data %h required no write",
                         mon_tgt, wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                if (mon_tgt !== mon_e.tgt || wr_addr !== mon_e.addr || wr_data !== mon_e.data
                    || cyc != mon_e.due) begin
                    mismatched++;
                    $display("[TB] FAIL write: got tgt %0d addr %0d data %h cyc %0d required tgt %0d addr %0d data %h cyc %0d",
                             mon_tgt, wr_addr, wr_data, cyc, mon_e.tgt, mon_e.addr, mon_e.data, mon_e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] hdr(input logic [1:0] t, input logic [15:0] c);
        return {t, 14'h2A5B, c};
    endfunction

    // Tasks are entered just after a falling edge and return just after one.
    task automatic send_word(input logic [DW-1:0] w, input bit payload,
                             input logic [1:0] tgt, input logic [AW-1:0] addr);
        int n = 0;
        stream_bus.s_valid = 1'b1;
        stream_bus.s_data  = w;
        while (stream_bus.s_ready !== 1'b1 && n < 20) begin
            @(negedge clk_CPU);
            n++;
        end
        if (n >= 20) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ready_timeout: got s_ready %b required 1 within 20 cycles", stream_bus.s_ready);
        end else if (payload) begin
            sb.push_back('{tgt, addr, w, cyc + 1});
        end
        @(negedge clk_CPU);
    endtask

    task automatic idle(input int n);
        stream_bus.s_valid = 1'b0;
        repeat (n) @(negedge clk_CPU);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_CPU);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_CPU            = 1'b1;
        start              = 1'b0;
        stream_bus.s_valid = 1'b0;
        stream_bus.s_data  = '0;
        repeat (3) @(negedge clk_CPU);
        compared++;
        if ({stream_bus.s_ready, rf_we, im_we, dm_we, busy, cpu_run, err, wr_addr, wr_data} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got rdy %b we %b%b%b busy %b run %b err %b addr %h data %h required all 0",
                     stream_bus.s_ready, rf_we, im_we, dm_we, busy, cpu_run, err, wr_addr, wr_data);
        end
        start = 1'b1;
        @(negedge clk_CPU);
        start = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL start_vs_reset: got busy %b required 0", busy);
        end
        rst_CPU = 1'b0;
        @(negedge clk_CPU);
        compared++;
        if ({busy, stream_bus.s_ready, cpu_run} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: got busy/rdy/run %b required 000", {busy, stream_bus.s_ready, cpu_run});
        end
    endtask

    task automatic test_rf_load();
        pulse_start();
        compared++;
        if ({busy, cpu_run, err, stream_bus.s_ready} !== 4'b1001) begin
            mismatched++;
            $display("[TB] FAIL session_start: got busy/run/err/rdy %b required 1001",
                     {busy, cpu_run, err, stream_bus.s_ready});
        end
        send_word(hdr(T_RF, 16'd2), 1'b0, T_RF, '0);
        send_word(32'd5, 1'b1, T_RF, 6'd0);
        send_word(32'd7, 1'b1, T_RF, 6'd1);
        send_word(hdr(T_END, 16'd0), 1'b0, T_RF, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if ({busy, cpu_run, err, stream_bus.s_ready} !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL rf_done: got busy/run/err/rdy %b required 0100",
                     {busy, cpu_run, err, stream_bus.s_ready});
        end
        idle(2);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL rf_writes_left: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_im_gaps();
        pulse_start();
        send_word(hdr(T_IM, 16'd3), 1'b0, T_IM, '0);
        for (int i = 0; i < 3; i++) begin
            stream_bus.s_valid = 1'b0;
            if (i == 1) start = 1'b1;
            @(negedge clk_CPU);
            start = 1'b0;
            send_word(32'hA000_0000 + 32'(i), 1'b1, T_IM, AW'(i));
        end
        idle(1);
        send_word(hdr(T_END, 16'd9), 1'b0, T_IM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if (cpu_run !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL im_done: got cpu_run %b required 1", cpu_run);
        end
        idle(2);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL im_writes_left: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_dm_overflow();
        pulse_start();
        send_word(hdr(T_DM, 16'd65), 1'b0, T_DM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if ({busy, cpu_run, err, stream_bus.s_ready} !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL overflow_err: got busy/run/err/rdy %b required 0010",
                     {busy, cpu_run, err, stream_bus.s_ready});
        end
        idle(3);
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_sticky: got err %b required 1", err);
        end
        pulse_start();
        compared++;
        if ({busy, cpu_run, err, stream_bus.s_ready} !== 4'b1001) begin
            mismatched++;
            $display("[TB] FAIL err_cleared: got busy/run/err/rdy %b required 1001",
                     {busy, cpu_run, err, stream_bus.s_ready});
        end
        send_word(hdr(T_END, 16'd0), 1'b0, T_DM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if (cpu_run !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overflow_recover: got cpu_run %b required 1", cpu_run);
        end
    endtask

    task automatic test_empty_section();
        pulse_start();
        send_word(hdr(T_DM, 16'd0), 1'b0, T_DM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if ({busy, stream_bus.s_ready, cpu_run} !== 3'b110) begin
            mismatched++;
            $display("[TB] FAIL empty_stays_hdr: got busy/rdy/run %b required 110",
                     {busy, stream_bus.s_ready, cpu_run});
        end
        send_word(hdr(T_END, 16'd0), 1'b0, T_DM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if ({busy, cpu_run, err} !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL empty_done: got busy/run/err %b required 010", {busy, cpu_run, err});
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        pulse_start();
        send_word(hdr(T_DM, 16'd64), 1'b0, T_DM, '0);
        t0 = cyc;
        for (int i = 0; i < 64; i++) begin
            send_word($urandom, 1'b1, T_DM, AW'(i));
        end
        t1 = cyc;
        compared++;
        if (t1 - t0 != 64) begin
            mismatched++;
            $display("[TB] FAIL throughput: got %0d cycles for 64 words required 64", t1 - t0);
        end
        send_word(hdr(T_DM, 16'd2), 1'b0, T_DM, '0);
        send_word(32'hDEAD_0000, 1'b1, T_DM, 6'd0);
        send_word(32'hDEAD_0001, 1'b1, T_DM, 6'd1);
        send_word(hdr(T_END, 16'd0), 1'b0, T_DM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if (cpu_run !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_done: got cpu_run %b required 1", cpu_run);
        end
        idle(2);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_writes_left: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_word(hdr(T_IM, 16'd4), 1'b0, T_IM, '0);
        send_word(32'h1111_0000, 1'b1, T_IM, 6'd0);
        send_word(32'h1111_0001, 1'b1, T_IM, 6'd1);
        stream_bus.s_valid = 1'b0;
        rst_CPU            = 1'b1;
        @(negedge clk_CPU);
        compared++;
        if ({stream_bus.s_ready, rf_we, im_we, dm_we, busy, cpu_run, err, wr_addr, wr_data} !== '0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got rdy %b we %b%b%b busy %b run %b err %b addr %h data %h required all 0",
                     stream_bus.s_ready, rf_we, im_we, dm_we, busy, cpu_run, err, wr_addr, wr_data);
        end
        rst_CPU = 1'b0;
        @(negedge clk_CPU);
        pulse_start();
        send_word(hdr(T_IM, 16'd4), 1'b0, T_IM, '0);
        for (int i = 0; i < 4; i++) begin
            send_word(32'h2222_0000 + 32'(i), 1'b1, T_IM, AW'(i));
        end
        send_word(hdr(T_END, 16'd0), 1'b0, T_IM, '0);
        stream_bus.s_valid = 1'b0;
        compared++;
        if ({busy, cpu_run, err} !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL reload_done: got busy/run/err %b required 010", {busy, cpu_run, err});
        end
        idle(2);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL reload_writes_left: got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_rf_load();
        test_im_gaps();
        test_dm_overflow();
        test_empty_section();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
